// File: rtl/video_crop.sv
// video_crop: rectangular window extraction on a de/hs/vs pixel stream.
// Optional build macro VIDEO_CROP_MARKER_EN paints the window border all ones.
module video_crop #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  crop_x,
    input  logic [CNT_WIDTH-1:0]  crop_y,
    input  logic [CNT_WIDTH-1:0]  crop_w,
    input  logic [CNT_WIDTH-1:0]  crop_h,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [CNT_WIDTH-1:0]  pix_count_o,
    output logic [CNT_WIDTH-1:0]  line_count_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_ACTIVE,
        S_FRAME_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_ONE = 1;
    localparam logic [CNT_WIDTH:0]   L_ONE = 1;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cx;
    logic [CNT_WIDTH-1:0]  r_cy;
    logic [CNT_WIDTH-1:0]  r_cw;
    logic [CNT_WIDTH-1:0]  r_ch;
    logic [CNT_WIDTH-1:0]  r_x_cnt;
    logic [CNT_WIDTH-1:0]  r_y_cnt;
    logic                  r_hs_d;
    logic                  r_vs_d;
    logic                  r_short;

    logic [CNT_WIDTH:0]    w_xend;
    logic [CNT_WIDTH:0]    w_yend;
    logic [CNT_WIDTH-1:0]  w_lines;
    logic [DATA_WIDTH-1:0] w_pix;
    logic                  w_hs_rise;
    logic                  w_vs_rise;
    logic                  w_in_x;
    logic                  w_in_y;
    logic                  w_in_win;
    logic                  w_past_x;
    logic                  w_last_row;
    logic                  w_win_en;
    logic                  w_line_short;
    logic                  w_err;
    logic                  w_fire;

    // Window ends carry one extra bit so x+w never wraps.
    assign w_xend    = {1'b0, r_cx} + {1'b0, r_cw};
    assign w_yend    = {1'b0, r_cy} + {1'b0, r_ch};
    assign w_hs_rise = hs_i & ~r_hs_d;
    assign w_vs_rise = vs_i & ~r_vs_d;

    assign w_in_x   = (r_x_cnt >= r_cx) && ({1'b0, r_x_cnt} < w_xend);
    assign w_in_y   = (r_y_cnt >= r_cy) && ({1'b0, r_y_cnt} < w_yend);
    assign w_in_win = de_i & ~hs_i & ~vs_i & w_in_x & w_in_y;
    assign w_past_x = {1'b0, r_x_cnt} >= w_xend;
    assign w_last_row = ({1'b0, r_y_cnt} + L_ONE) >= w_yend;
    assign w_win_en = (r_cw != '0) && (r_ch != '0);
    assign w_fire   = w_in_win &&
                      (r_state == S_WAIT_FRAME || r_state == S_ACTIVE);

    // A line that closes together with vs_i still counts toward the frame.
    assign w_lines = r_y_cnt + {{(CNT_WIDTH-1){1'b0}}, w_hs_rise};
    assign w_line_short = w_hs_rise && w_in_y && !w_past_x;
    assign w_err = w_win_en &&
                   (({1'b0, w_lines} < w_yend) || r_short || w_line_short);

`ifdef VIDEO_CROP_MARKER_EN
    logic w_border;

    assign w_border = (r_x_cnt == r_cx) ||
                      ({1'b0, r_x_cnt} == (w_xend - L_ONE)) ||
                      (r_y_cnt == r_cy) ||
                      ({1'b0, r_y_cnt} == (w_yend - L_ONE));
    assign w_pix = w_border ? '1 : di_i;
`else
    assign w_pix = di_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cx         <= '0;
            r_cy         <= '0;
            r_cw         <= '0;
            r_ch         <= '0;
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_hs_d       <= 1'b1;
            r_vs_d       <= 1'b1;
            r_short      <= 1'b0;
            pix_count_o  <= '0;
            line_count_o <= '0;
            err_o        <= 1'b0;
        end else begin
            r_hs_d <= hs_i;
            r_vs_d <= vs_i;
            if (vs_i) begin
                r_cx <= crop_x;
                r_cy <= crop_y;
                r_cw <= crop_w;
                r_ch <= crop_h;
            end
            if (hs_i) begin
                r_x_cnt <= '0;
            end else if (de_i) begin
                r_x_cnt <= r_x_cnt + C_ONE;
            end
            if (vs_i) begin
                r_y_cnt <= '0;
            end else if (w_hs_rise) begin
                r_y_cnt <= r_y_cnt + C_ONE;
            end
            if (vs_i) begin
                r_short <= 1'b0;
            end else if (w_line_short) begin
                r_short <= 1'b1;
            end
            if (w_hs_rise) begin
                pix_count_o <= r_x_cnt;
            end
            if (w_vs_rise) begin
                line_count_o <= w_lines;
            end
            err_o <= w_vs_rise && w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            do_o    <= '0;
            de_o    <= 1'b0;
            hs_o    <= 1'b1;
            vs_o    <= 1'b1;
        end else begin
            de_o <= 1'b0;
            if (w_fire) begin
                do_o <= w_pix;
            end
            unique case (r_state)
                S_IDLE: begin
                    hs_o <= 1'b1;
                    vs_o <= 1'b1;
                    if (vs_i) begin
                        r_state <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (w_in_win) begin
                        de_o    <= 1'b1;
                        hs_o    <= 1'b0;
                        vs_o    <= 1'b0;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (vs_i) begin
                        hs_o    <= 1'b1;
                        vs_o    <= 1'b1;
                        r_state <= S_FRAME_DONE;
                    end else if (w_in_win) begin
                        de_o <= 1'b1;
                        hs_o <= 1'b0;
                    end else if (w_past_x || hs_i) begin
                        hs_o <= 1'b1;
                        // During hblank y_cnt already points at the next row.
                        if (w_last_row && (w_hs_rise || !hs_i)) begin
                            vs_o    <= 1'b1;
                            r_state <= S_FRAME_DONE;
                        end
                    end
                end
                S_FRAME_DONE: begin
                    hs_o <= 1'b1;
                    vs_o <= 1'b1;
                    if (vs_i) begin
                        r_state <= S_WAIT_FRAME;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_crop.sv
// tb_video_crop: directed frames through video_crop with a queued scoreboard.
// A negedge monitor pops expected pixels, line lengths and err_o cycles.
module tb_video_crop;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] crop_x = '0;
    logic [CW-1:0] crop_y = '0;
    logic [CW-1:0] crop_w = '0;
    logic [CW-1:0] crop_h = '0;
    logic [DW-1:0] di_i = '0;
    logic          de_i = 1'b0;
    logic          hs_i = 1'b1;
    logic          vs_i = 1'b1;
    logic [DW-1:0] do_o;
    logic          de_o;
    logic          hs_o;
    logic          vs_o;
    logic [CW-1:0] pix_count_o;
    logic [CW-1:0] line_count_o;
    logic          err_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_de = 0;
    int cur_len = 0;
    int e_val;
    int e_t;
    bit mon_en = 1'b0;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;

    int exp_q[$];
    int exp_t[$];
    int line_q[$];
    int err_q[$];

    video_crop #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .crop_x(crop_x),
        .crop_y(crop_y),
        .crop_w(crop_w),
        .crop_h(crop_h),
        .di_i(di_i),
        .de_i(de_i),
        .hs_i(hs_i),
        .vs_i(vs_i),
        .do_o(do_o),
        .de_o(de_o),
        .hs_o(hs_o),
        .vs_o(vs_o),
        .pix_count_o(pix_count_o),
        .line_count_o(line_count_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_do", int'(do_o), 0);
        chk("rst_de", int'(de_o), 0);
        chk("rst_hs", int'(hs_o), 1);
        chk("rst_vs", int'(vs_o), 1);
        chk("rst_pix_count", int'(pix_count_o), 0);
        chk("rst_line_count", int'(line_count_o), 0);
        chk("rst_err", int'(err_o), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (de_o) begin
                n_de++;
                cur_len++;
                if (exp_q.size() != 0) begin
                    e_val = exp_q.pop_front();
                    e_t = exp_t.pop_front();
                end else begin
                    e_val = -1;
                    e_t = -1;
                end
                chk("pixel", int'(do_o), e_val);
                chk("pixel_latency", cyc, e_t);
                chk("sync_low_on_de", int'({hs_o, vs_o}), 0);
            end
            if (prev_hs && !hs_o) chk("hs_fall_with_de", int'(de_o), 1);
            if (prev_vs && !vs_o) chk("vs_fall_with_de", int'(de_o), 1);
            if (!prev_hs && hs_o) begin
                e_val = (line_q.size() != 0) ? line_q.pop_front() : -1;
                chk("line_len", cur_len, e_val);
                cur_len = 0;
            end
            if (err_o) begin
                e_val = (err_q.size() != 0) ? err_q.pop_front() : -1;
                chk("err_cycle", cyc, e_val);
            end
        end
        prev_hs = hs_o;
        prev_vs = vs_o;
    end

    // rl: line index at which rst pulses (>= h for none); chl/chw: mid-frame crop_w change.
    task automatic frame(input int w, input int h, input int per,
                         input int rl, input int chl, input int chw,
                         input bit konst, input int tot);
        int ex, ey, ew, eh, base, len, md;
        logic [DW-1:0] d;
        ex = int'(crop_x);
        ey = int'(crop_y);
        ew = int'(crop_w);
        eh = int'(crop_h);
        vs_i = 1'b1;
        hs_i = 1'b1;
        de_i = 1'b0;
        repeat (6) tick();
        vs_i = 1'b0;
        repeat (2) tick();
        base = n_de;
        for (int y = 0; y < h; y++) begin
            if (y == rl) begin
                rst = 1'b1;
                tick();
                chk_reset();
                rst = 1'b0;
            end
            if (y == chl) crop_w = chw[CW-1:0];
            len = 0;
            for (int x = ex; x < ex + ew && x < w; x++) len++;
            if (y < rl && ew > 0 && eh > 0 && y >= ey && y < ey + eh && len > 0)
                line_q.push_back(len);
            hs_i = 1'b0;
            for (int x = 0; x < w; x++) begin
                d = konst ? 8'h40 : 8'(x + w * y);
                di_i = d;
                de_i = 1'b1;
                if (y < rl && x >= ex && x < ex + ew && y >= ey && y < ey + eh) begin
                    md = int'(d);
`ifdef VIDEO_CROP_MARKER_EN
                    if (x == ex || x == ex + ew - 1 || y == ey || y == ey + eh - 1)
                        md = 255;
`endif
                    exp_q.push_back(md);
                    exp_t.push_back(cyc + 1);
                end
                tick();
                de_i = 1'b0;
                repeat (per - 1) tick();
            end
            hs_i = 1'b1;
            if (y == h - 1) begin
                vs_i = 1'b1;
                if (rl >= h && ew > 0 && eh > 0 && (ey + eh > h || ex + ew > w))
                    err_q.push_back(cyc + 1);
            end
            repeat (4) tick();
        end
        repeat (4) tick();
        chk("frame_de_total", n_de - base, tot);
        if (rl >= h) begin
            chk("line_count", int'(line_count_o), h);
            chk("pix_count", int'(pix_count_o), w);
        end
    endtask

    task automatic set_crop(input int x, input int y, input int w, input int h);
        crop_x = x[CW-1:0];
        crop_y = y[CW-1:0];
        crop_w = w[CW-1:0];
        crop_h = h[CW-1:0];
    endtask

    initial begin
        repeat (3) tick();
        chk_reset();
        rst = 1'b0;
        mon_en = 1'b1;

        set_crop(0, 0, 20, 12);
        frame(20, 12, 2, 99, -1, 0, 1'b0, 240);
        set_crop(3, 2, 8, 5);
        frame(20, 12, 3, 99, -1, 0, 1'b0, 40);
        set_crop(16, 9, 8, 8);
        frame(20, 12, 1, 99, -1, 0, 1'b0, 12);
        set_crop(3, 2, 8, 5);
        frame(20, 12, 2, 99, 4, 4, 1'b0, 40);
        frame(20, 12, 2, 99, -1, 0, 1'b0, 20);
        set_crop(0, 0, 20, 12);
        frame(20, 12, 1, 5, -1, 0, 1'b0, 100);
        set_crop(2, 1, 5, 3);
        frame(20, 12, 2, 99, -1, 0, 1'b0, 15);
        set_crop(0, 0, 0, 5);
        frame(20, 12, 1, 99, -1, 0, 1'b0, 0);
        set_crop(0, 0, 8, 4);
        frame(20, 12, 1, 99, -1, 0, 1'b1, 32);

        repeat (4) tick();
        chk("pixels_left", exp_q.size(), 0);
        chk("lines_left", line_q.size(), 0);
        chk("errs_left", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
